prog_seq_gen: RTL and testbench
===============================

# prog_seq_gen

Programmable, parametrised sequence generator. A register-based pattern table of DEPTH entries, each WIDTH bits wide, is stepped through by a small controller that supports one-shot and cyclic playback, a runtime-selectable length, and optional reverse playback. After reset the table holds the odd-step pattern 0,1,3,5,7,… so existing fixed-sequence users keep working. Sits between the lab control logic and the output drivers (LEDs, counters, display mux) wherever a repeating state pattern is needed.

## Interface
- WIDTH, 3, bits per sequence value.
- DEPTH, 8, table entries; DEPTH ≥ 2. AW = $clog2(DEPTH).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin playback, or restart it, from the first index.
- stop  input  1  abort playback and return to IDLE.
- cyclic  input  1  1 = wrap and repeat; 0 = one-shot. Sampled on start.
- dir  input  1  0 = forward, 1 = reverse. Sampled on start; see Configuration.
- cfg_len  input  AW+1  active entries. Sampled on start; 0 or >DEPTH is treated as DEPTH.
- wr_en  input  1  table write strobe.
- wr_addr  input  AW  table write index; writes with wr_addr ≥ DEPTH are dropped.
- wr_data  input  WIDTH  table write data.
- Q  output  WIDTH  current sequence value (registered).
- idx  output  AW  table index currently driving Q.
- busy  output  1  high in RUN.
- wrap  output  1  one-cycle pulse when the index wraps (cyclic mode).
- done  output  1  one-cycle pulse when one-shot playback completes or is stopped.

## Operation
- States: IDLE, RUN. Reset → IDLE.
- Reset values: Q=0, idx=0, busy=0, wrap=0, done=0. Table entry 0 = 0; entry i (i ≥ 1) = (2i−1) mod 2^WIDTH.
- Table writes are accepted only in IDLE. Writes in RUN are ignored.
- IDLE, start=1: latch L (effective length), cyclic and dir, then go to RUN.
  - First index F = 0 when forward, L−1 when reverse.
  - idx ← F, Q ← table[F].
- RUN, each cycle with no start/stop: advance the index (+1 forward, −1 reverse).
  - The last index is L−1 forward, 0 reverse.
  - At the last index with cyclic=1: idx ← F, Q ← table[F], wrap=1 in the same cycle Q shows table[F].
  - At the last index with cyclic=0: go to IDLE, done=1, Q and idx hold the last entry.
- RUN, stop=1: go to IDLE, done=1, Q and idx hold their values.
- RUN, start=1 (stop=0): restart. Re-latch the configuration, then idx ← F, Q ← table[F]. No wrap pulse.
- Simultaneous events:
  - stop beats start.
  - wr_en together with start in IDLE: the write commits, and Q loads the pre-write contents of table[F].
- L=1: forward and reverse are identical. Cyclic mode pulses wrap every cycle after the first. One-shot mode finishes after one cycle.
- Reset asserted mid-playback: at the next edge, all outputs and the table return to reset values and the controller enters IDLE.

## Timing
- start sampled at edge k → Q=table[F], busy=1 after edge k (latency 1).
- Each following edge advances one entry. A cyclic period is exactly L cycles.
- wrap and done are high for exactly one cycle, coincident with the Q update that triggers them.
- busy drops in the same cycle done rises.
- A table write at edge k is visible to a start sampled at edge k+1 or later.

## Configuration
- PROG_SEQ_GEN_REVERSE_EN defined: dir is honoured as described above.
- PROG_SEQ_GEN_REVERSE_EN undefined: dir is ignored and playback is always forward. Reverse next-index logic is not built.

## Test plan
- Reset, then cfg_len=5, cyclic=1, dir=0, start pulse → Q = 0,1,3,5,7,0,1,… with wrap high each time Q returns to 0 (every 5 cycles).
- In IDLE, write table[0..3]=6,2,4,1; cfg_len=4, cyclic=0, start → Q = 6,2,4,1, then done=1, busy=0, Q holds 1.
- With REVERSE_EN defined: reset defaults, cfg_len=5, dir=1, cyclic=1 → Q = 7,5,3,1,0,7,… with wrap on each return to 7. With REVERSE_EN undefined: same stimulus gives the forward sequence.
- During RUN, wr_en with wr_addr=0, wr_data=4 → table unchanged; after stop, a restart still shows Q=0 first. Also stop and start in the same cycle → IDLE, done=1, Q held.
- Reset pulse mid-run at Q=5 → next cycle Q=0, idx=0, busy=0, and user writes are lost (table[1] reads back as 1). cfg_len=0 → plays all 8 entries: 0,1,3,5,7,1,3,5.

Source files
------------

// File: rtl/prog_seq_gen_if.sv
// Control, table-write and output signals of the programmable sequence generator.
// The master side drives the controls and the slave side is the generator itself.
interface prog_seq_gen_if #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             start;
  logic             stop;
  logic             cyclic;
  logic             dir;
  logic [AW:0]      cfg_len;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] Q;
  logic [AW-1:0]    idx;
  logic             busy;
  logic             wrap;
  logic             done;

  modport master (
    output start, stop, cyclic, dir, cfg_len, wr_en, wr_addr, wr_data,
    input  Q, idx, busy, wrap, done
  );

  modport slave (
    input  start, stop, cyclic, dir, cfg_len, wr_en, wr_addr, wr_data,
    output Q, idx, busy, wrap, done
  );
endinterface

// File: rtl/prog_seq_gen.sv
// Programmable sequence generator: register pattern table stepped in one-shot or cyclic mode.
// Define PROG_SEQ_GEN_REVERSE_EN to build reverse playback; otherwise dir is ignored.
module prog_seq_gen #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input logic          clk,
  input logic          reset,
  prog_seq_gen_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE = 1;
  localparam logic [AW-1:0] IDX_ONE = 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] seq_tab [DEPTH];
  logic [AW:0]      len_q;
  logic             cyclic_q;
  logic [AW-1:0]    idx_q;
  logic [WIDTH-1:0] q_q;
  logic             wrap_q;
  logic             done_q;

  logic [AW:0]      eff_len;
  logic [AW:0]      eff_len_m1;
  logic [AW:0]      len_m1;
  logic             wr_ok;
  logic [AW-1:0]    start_idx;
  logic [AW-1:0]    first_idx;
  logic [AW-1:0]    last_idx;
  logic [AW-1:0]    next_idx;
  logic             dir_in;

  function automatic logic [WIDTH-1:0] reset_val(input int i);
    return (i == 0) ? '0 : WIDTH'(2 * i - 1);
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    eff_len = bus.cfg_len;
    if (bus.cfg_len == '0 || bus.cfg_len > DEPTH_L)
      eff_len = DEPTH_L;
    eff_len_m1 = eff_len - LEN_ONE;
    len_m1     = len_q - LEN_ONE;
    wr_ok      = ({1'b0, bus.wr_addr} < DEPTH_L);
  end

`ifdef PROG_SEQ_GEN_REVERSE_EN
  logic dir_q;

  assign dir_in    = bus.dir;
  assign start_idx = dir_in ? eff_len_m1[AW-1:0] : '0;
  assign first_idx = dir_q ? len_m1[AW-1:0] : '0;
  assign last_idx  = dir_q ? '0 : len_m1[AW-1:0];
  assign next_idx  = dir_q ? idx_q - IDX_ONE : idx_q + IDX_ONE;

  always_ff @(posedge clk) begin
    if (reset)
      dir_q <= 1'b0;
    else if (bus.start && !(state == RUN && bus.stop))
      dir_q <= dir_in;
  end
`else
  logic unused_dir;

  assign unused_dir = bus.dir;
  assign dir_in     = 1'b0;
  assign start_idx  = '0;
  assign first_idx  = '0;
  assign last_idx   = len_m1[AW-1:0];
  assign next_idx   = idx_q + IDX_ONE;
`endif

  // NOTE: the table is plain flops reset to the odd-step pattern, so it must be cleared here with the rest.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= DEPTH_L;
      cyclic_q <= 1'b0;
      idx_q    <= '0;
      q_q      <= '0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        seq_tab[i] <= reset_val(i);
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      if (state == IDLE && bus.wr_en && wr_ok)
        seq_tab[bus.wr_addr] <= bus.wr_data;

      case (state)
        IDLE: begin
          if (bus.start) begin
            // NOTE: non-blocking writes mean this read sees the table before a same-cycle write.
            state    <= RUN;
            len_q    <= eff_len;
            cyclic_q <= bus.cyclic;
            idx_q    <= start_idx;
            q_q      <= seq_tab[start_idx];
          end
        end
        default: begin
          if (bus.stop) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else if (bus.start) begin
            len_q    <= eff_len;
            cyclic_q <= bus.cyclic;
            idx_q    <= start_idx;
            q_q      <= seq_tab[start_idx];
          end else if (idx_q == last_idx) begin
            if (cyclic_q) begin
              idx_q  <= first_idx;
              q_q    <= seq_tab[first_idx];
              wrap_q <= 1'b1;
            end else begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end else begin
            idx_q <= next_idx;
            q_q   <= seq_tab[next_idx];
          end
        end
      endcase
    end
  end

  assign bus.Q    = q_q;
  assign bus.idx  = idx_q;
  assign bus.busy = (state == RUN);
  assign bus.wrap = wrap_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_prog_seq_gen.sv
// Self-checking bench for prog_seq_gen: directed scenarios plus randomized traffic
// compared each cycle against a playback-position model of the generator.
module tb_prog_seq_gen;
  localparam int WIDTH = 3;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic clk   = 1'b0;
  logic reset = 1'b1;

  prog_seq_gen_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  prog_seq_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

`ifdef PROG_SEQ_GEN_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  // Reference model: playback tracked as a step position 0..len-1 mapped onto the table.
  logic [WIDTH-1:0] m_tab [DEPTH];
  bit               m_busy, m_cyc, m_dir, m_wrap, m_done;
  int               m_pos, m_len;
  logic [WIDTH-1:0] m_q;
  logic [AW-1:0]    m_idx;

  function automatic int order(input int p);
    return m_dir ? (m_len - 1 - p) : p;
  endfunction

  function automatic void model_step();
    logic [WIDTH-1:0] old_tab [DEPTH];
    old_tab = m_tab;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_tab[i] = (i == 0) ? '0 : WIDTH'(2 * i - 1);
      m_busy = 0; m_q = '0; m_idx = '0; m_wrap = 0; m_done = 0; m_pos = 0;
      return;
    end
    m_wrap = 0;
    m_done = 0;
    if (!m_busy && bus.wr_en && int'(bus.wr_addr) < DEPTH) m_tab[bus.wr_addr] = bus.wr_data;
    if (bus.start && !(m_busy && bus.stop)) begin
      m_len  = (bus.cfg_len == 0 || int'(bus.cfg_len) > DEPTH) ? DEPTH : int'(bus.cfg_len);
      m_cyc  = bus.cyclic;
      m_dir  = REV && bus.dir;
      m_pos  = 0;
      m_busy = 1;
      m_idx  = AW'(order(0));
      m_q    = old_tab[order(0)];
    end else if (m_busy) begin
      if (bus.stop) begin
        m_busy = 0; m_done = 1;
      end else if (m_pos == m_len - 1 && !m_cyc) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_wrap = (m_pos == m_len - 1);
        m_pos  = m_wrap ? 0 : m_pos + 1;
        m_idx  = AW'(order(m_pos));
        m_q    = m_tab[order(m_pos)];
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.stop = 0; bus.cyclic = 0; bus.dir = 0; bus.cfg_len = '0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    for (int k = 0; k < 3; k++) begin
      bus.start = 1'($urandom); bus.wr_en = 1'($urandom); bus.cfg_len = (AW+1)'($urandom);
      cycle();
      checks++;
      if ({bus.Q, bus.idx, bus.busy, bus.wrap, bus.done} !== '0) begin
        failures++;
        $display("FAIL reset_state k=%0d got Q=%0d idx=%0d busy=%0b wrap=%0b done=%0b want all zero",
                 k, bus.Q, bus.idx, bus.busy, bus.wrap, bus.done);
      end
    end
    clear_inputs();
    reset = 0;
    cycle();
  endtask

  task automatic test_cyclic_forward();
    logic [WIDTH-1:0] seq [5];
    seq = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd7};
    do_reset();
    bus.cfg_len = 5; bus.cyclic = 1; bus.dir = 0; bus.start = 1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      bus.start = 0;
      checks++;
      if ({bus.Q, bus.wrap, bus.busy} !== {seq[k % 5], (k >= 5 && k % 5 == 0), 1'b1}) begin
        failures++;
        $display("FAIL cyclic_fwd k=%0d got Q=%0d wrap=%0b busy=%0b want Q=%0d wrap=%0b busy=1",
                 k, bus.Q, bus.wrap, bus.busy, seq[k % 5], (k >= 5 && k % 5 == 0));
      end
    end
    bus.stop = 1;
    cycle();
    bus.stop = 0;
    checks++;
    if ({bus.busy, bus.done} !== 2'b01) begin
      failures++;
      $display("FAIL cyclic_fwd_stop got busy=%0b done=%0b want busy=0 done=1", bus.busy, bus.done);
    end
  endtask

  task automatic test_oneshot_write();
    logic [WIDTH-1:0] seq [4];
    seq = '{3'd6, 3'd2, 3'd4, 3'd1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1; bus.wr_addr = AW'(i); bus.wr_data = seq[i];
      cycle();
    end
    bus.wr_en = 0;
    bus.cfg_len = 4; bus.cyclic = 0; bus.start = 1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      bus.start = 0;
      checks++;
      if (k < 4) begin
        if ({bus.Q, bus.busy, bus.done} !== {seq[k], 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL oneshot k=%0d got Q=%0d busy=%0b done=%0b want Q=%0d busy=1 done=0",
                   k, bus.Q, bus.busy, bus.done, seq[k]);
        end
      end else if ({bus.Q, bus.idx, bus.busy, bus.done} !== {3'd1, 3'd3, 1'b0, (k == 4)}) begin
        failures++;
        $display("FAIL oneshot_end k=%0d got Q=%0d idx=%0d busy=%0b done=%0b want Q=1 idx=3 busy=0 done=%0b",
                 k, bus.Q, bus.idx, bus.busy, bus.done, (k == 4));
      end
    end
  endtask

  task automatic test_reverse();
    logic [WIDTH-1:0] seq [5];
    if (REV) seq = '{3'd7, 3'd5, 3'd3, 3'd1, 3'd0};
    else     seq = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd7};
    do_reset();
    bus.cfg_len = 5; bus.cyclic = 1; bus.dir = 1; bus.start = 1;
    for (int k = 0; k < 11; k++) begin
      cycle();
      bus.start = 0;
      checks++;
      if ({bus.Q, bus.wrap} !== {seq[k % 5], (k >= 5 && k % 5 == 0)}) begin
        failures++;
        $display("FAIL reverse k=%0d got Q=%0d wrap=%0b want Q=%0d wrap=%0b",
                 k, bus.Q, bus.wrap, seq[k % 5], (k >= 5 && k % 5 == 0));
      end
    end
    bus.stop = 1;
    cycle();
    bus.stop = 0;
  endtask

  task automatic test_run_write_and_stop();
    logic [WIDTH-1:0] held;
    do_reset();
    bus.cfg_len = 8; bus.cyclic = 1; bus.start = 1;
    cycle();
    bus.start = 0;
    bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = 4;
    for (int k = 0; k < 3; k++) cycle();
    held = bus.Q;
    bus.stop = 1;
    cycle();
    bus.stop = 0; bus.wr_en = 0;
    checks++;
    if ({bus.Q, bus.busy, bus.done} !== {held, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL run_stop got Q=%0d busy=%0b done=%0b want Q=%0d busy=0 done=1",
               bus.Q, bus.busy, bus.done, held);
    end
    bus.start = 1;
    cycle();
    bus.start = 0;
    checks++;
    if ({bus.Q, bus.busy} !== {3'd0, 1'b1}) begin
      failures++;
      $display("FAIL run_write_ignored got Q=%0d busy=%0b want Q=0 busy=1", bus.Q, bus.busy);
    end
    cycle();
    cycle();
    held = bus.Q;
    bus.stop = 1; bus.start = 1;
    cycle();
    bus.stop = 0; bus.start = 0;
    checks++;
    if ({bus.Q, bus.busy, bus.done} !== {held, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL stop_beats_start got Q=%0d busy=%0b done=%0b want Q=%0d busy=0 done=1",
               bus.Q, bus.busy, bus.done, held);
    end
  endtask

  task automatic test_reset_midrun_len0();
    logic [WIDTH-1:0] seq [8];
    seq = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd7, 3'd1, 3'd3, 3'd5};
    do_reset();
    bus.wr_en = 1; bus.wr_addr = 1; bus.wr_data = 6;
    cycle();
    bus.wr_en = 0;
    bus.cfg_len = 5; bus.cyclic = 1; bus.start = 1;
    cycle();
    bus.start = 0;
    for (int k = 0; k < 3; k++) cycle();
    checks++;
    if (bus.Q !== 3'd5) begin
      failures++;
      $display("FAIL midrun_pre got Q=%0d want Q=5", bus.Q);
    end
    reset = 1;
    cycle();
    reset = 0;
    checks++;
    if ({bus.Q, bus.idx, bus.busy} !== '0) begin
      failures++;
      $display("FAIL midrun_reset got Q=%0d idx=%0d busy=%0b want 0 0 0", bus.Q, bus.idx, bus.busy);
    end
    bus.cfg_len = 0; bus.cyclic = 0; bus.start = 1;
    for (int k = 0; k < 9; k++) begin
      cycle();
      bus.start = 0;
      checks++;
      if (k < 8) begin
        if ({bus.Q, bus.busy} !== {seq[k], 1'b1}) begin
          failures++;
          $display("FAIL len0 k=%0d got Q=%0d busy=%0b want Q=%0d busy=1", k, bus.Q, bus.busy, seq[k]);
        end
      end else if ({bus.Q, bus.busy, bus.done} !== {3'd5, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL len0_done got Q=%0d busy=%0b done=%0b want Q=5 busy=0 done=1",
                 bus.Q, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(199) == 0);
      bus.start   = ($urandom_range(9) == 0);
      bus.stop    = ($urandom_range(19) == 0);
      bus.cyclic  = 1'($urandom);
      bus.dir     = 1'($urandom);
      bus.cfg_len = (AW+1)'($urandom);
      bus.wr_en   = ($urandom_range(3) == 0);
      bus.wr_addr = AW'($urandom);
      bus.wr_data = WIDTH'($urandom);
      cycle();
      checks++;
      if ({bus.Q, bus.idx, bus.busy, bus.wrap, bus.done} !== {m_q, m_idx, m_busy, m_wrap, m_done}) begin
        failures++;
        $display("FAIL random c=%0d got Q=%0d idx=%0d busy=%0b wrap=%0b done=%0b want Q=%0d idx=%0d busy=%0b wrap=%0b done=%0b",
                 c, bus.Q, bus.idx, bus.busy, bus.wrap, bus.done, m_q, m_idx, m_busy, m_wrap, m_done);
      end
    end
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_cyclic_forward();
    test_oneshot_write();
    test_reverse();
    test_run_write_and_stop();
    test_reset_midrun_len0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
